// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception/interrupt unit (M stage): holds SR, Cause, EPC and PrID.
// It raises IntReq, which flushes the pipeline and redirects it, and it serves mfc0, mtc0 and eret.
module cp0_exc_unit #(
  parameter logic [31:0] PRID      = 32'h2018_1210,
  parameter logic [31:0] EPC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCM,
  input  logic        BDM,
  input  logic [4:0]  ExcCodeM,
  input  logic [5:0]  HWInt,
  input  logic [4:0]  A1,
  input  logic [31:0] DIn,
  input  logic        WeCP0,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IM_W  = 6;
  localparam int unsigned EXC_W = 5;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [IM_W-1:0]  sr_im;
  logic             sr_exl;
  logic             sr_ie;
  logic             cause_bd;
  logic [IM_W-1:0]  cause_ip;
  logic [EXC_W-1:0] cause_exc;
  logic [XLEN-1:0]  epc_q;

  logic             int_pend;
  logic             exc_pend;
  logic [XLEN-1:0]  epc_raw;
  logic [XLEN-1:0]  sr_word;
  logic [XLEN-1:0]  cause_word;

  // Request decision: an interrupt or exception is taken only while outside a handler.
  always_comb begin
    int_pend = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    exc_pend = (ExcCodeM != 5'd0) & ~sr_exl;
    IntReq   = int_pend | exc_pend;
    epc_raw  = BDM ? (PCM - XLEN'(4)) : PCM;
  end

  always_comb begin
    sr_word    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
    cause_word = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
    EPC        = epc_q;
  end

  // mfc0 read mux; there is no bypass, so a read sees state as of the last edge.
  always_comb begin
    DOut = '0;
    unique case (A1)
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc_q;
      REG_PRID:  DOut = PRID;
      default:   DOut = '0;
    endcase
  end

  // Commit order: take exception/interrupt > eret > mtc0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc_q     <= EPC_RESET;
    end else begin
      cause_ip <= HWInt;
      if (IntReq) begin
        sr_exl    <= 1'b1;
        cause_bd  <= BDM;
        epc_q     <= epc_raw & WORD_MASK;
        cause_exc <= int_pend ? EXC_W'(0) : ExcCodeM;
      end else if (EXLClr) begin
        sr_exl <= 1'b0;
      end else if (WeCP0) begin
        if (A1 == REG_SR) begin
          sr_im  <= DIn[15:10];
          sr_exl <= DIn[1];
          sr_ie  <= DIn[0];
        end else if (A1 == REG_EPC) begin
          epc_q <= DIn & WORD_MASK;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit. The driver queues the outputs it expects for each cycle,
// and a monitor compares them against the DUT mid-cycle.
module tb_cp0_exc_unit;

  localparam logic [31:0] PRID      = 32'h2018_1210;
  localparam logic [31:0] EPC_RESET = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic [31:0] PCM;
  logic        BDM;
  logic [4:0]  ExcCodeM;
  logic [5:0]  HWInt;
  logic [4:0]  A1;
  logic [31:0] DIn;
  logic        WeCP0;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  typedef struct {
    string       nm;
    bit          ci;
    logic        ei;
    bit          cd;
    logic [31:0] ed;
    bit          ce;
    logic [31:0] ee;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  cp0_exc_unit #(.PRID(PRID), .EPC_RESET(EPC_RESET)) dut (
    .clk(clk), .reset(reset), .PCM(PCM), .BDM(BDM), .ExcCodeM(ExcCodeM),
    .HWInt(HWInt), .A1(A1), .DIn(DIn), .WeCP0(WeCP0), .EXLClr(EXLClr),
    .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops one expectation per cycle and samples the outputs on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.ci) begin
        total++;
        if (IntReq !== e.ei) begin
          bad++;
          $display("FAIL %s IntReq got=%0h exp=%0h", e.nm, IntReq, e.ei);
        end
      end
      if (e.cd) begin
        total++;
        if (DOut !== e.ed) begin
          bad++;
          $display("FAIL %s DOut got=%08h exp=%08h", e.nm, DOut, e.ed);
        end
      end
      if (e.ce) begin
        total++;
        if (EPC !== e.ee) begin
          bad++;
          $display("FAIL %s EPC got=%08h exp=%08h", e.nm, EPC, e.ee);
        end
      end
    end
  end

  task automatic drv(input logic [4:0] a1, input logic [31:0] din, input logic we,
                     input logic clr, input logic [4:0] exc, input logic bd,
                     input logic [31:0] pc, input logic [5:0] hw);
    A1 = a1; DIn = din; WeCP0 = we; EXLClr = clr;
    ExcCodeM = exc; BDM = bd; PCM = pc; HWInt = hw;
  endtask

  task automatic expect_c(input string nm, input bit ci, input logic ei,
                          input bit cd, input logic [31:0] ed,
                          input bit ce, input logic [31:0] ee);
    exp_t e;
    e.nm = nm; e.ci = ci; e.ei = ei; e.cd = cd; e.ed = ed; e.ce = ce; e.ee = ee;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drv(5'd14, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 6'd0);
    #1;
    expect_c("rst_hold", 1, 1'b0, 1, EPC_RESET, 1, EPC_RESET);
    tick(); tick();
    reset = 1'b1;

    drv(5'd12, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 6'd0);
    expect_c("rd_sr", 1, 1'b0, 1, 32'h0, 1, EPC_RESET); tick();
    drv(5'd13, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 6'd0);
    expect_c("rd_cause", 0, 1'b0, 1, 32'h0, 0, 32'h0); tick();
    drv(5'd14, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 6'd0);
    expect_c("rd_epc", 0, 1'b0, 1, EPC_RESET, 0, 32'h0); tick();
    drv(5'd15, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 6'd0);
    expect_c("rd_prid", 0, 1'b0, 1, PRID, 0, 32'h0); tick();

    // Enable IE and IM[0], then raise HWInt[0].
    drv(5'd12, 32'h0000_0401, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 6'd0);
    expect_c("mtc0_sr", 1, 1'b0, 1, 32'h0, 0, 32'h0); tick();
    drv(5'd12, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h3020, 6'b000001);
    expect_c("int_take", 1, 1'b1, 1, 32'h0000_0401, 1, EPC_RESET); tick();
    drv(5'd12, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h3024, 6'b000001);
    expect_c("int_exl", 1, 1'b0, 1, 32'h0000_0403, 1, 32'h3020); tick();
    drv(5'd13, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h3028, 6'b000001);
    expect_c("int_cause", 1, 1'b0, 1, 32'h0000_0400, 0, 32'h0); tick();
    drv(5'd13, 32'd0, 1'b0, 1'b0, 5'd5, 1'b0, 32'h302C, 6'b000001);
    expect_c("nest_exc", 1, 1'b0, 0, 32'h0, 1, 32'h3020); tick();
    drv(5'd12, 32'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h3030, 6'b000001);
    expect_c("eret", 1, 1'b0, 1, 32'h0000_0403, 0, 32'h0); tick();
    drv(5'd12, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h3040, 6'b000001);
    expect_c("held_int", 1, 1'b1, 1, 32'h0000_0401, 0, 32'h0); tick();
    drv(5'd12, 32'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h3044, 6'd0);
    expect_c("eret2", 1, 1'b0, 0, 32'h0, 1, 32'h3040); tick();

    // Exception in delay slot with IE=0; the pending HWInt must not matter.
    drv(5'd12, 32'h0000_0400, 1'b1, 1'b0, 5'd0, 1'b0, 32'h3048, 6'd0);
    expect_c("sr_ie0", 1, 1'b0, 0, 32'h0, 0, 32'h0); tick();
    drv(5'd12, 32'd0, 1'b0, 1'b0, 5'd12, 1'b1, 32'h3010, 6'b000001);
    expect_c("ov_take", 1, 1'b1, 1, 32'h0000_0400, 0, 32'h0); tick();
    drv(5'd13, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h3014, 6'd0);
    expect_c("ov_cause", 1, 1'b0, 1, 32'h8000_0430, 1, 32'h300C); tick();
    drv(5'd12, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h3018, 6'd0);
    expect_c("ov_sr", 0, 1'b0, 1, 32'h0000_0402, 0, 32'h0); tick();
    drv(5'd12, 32'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h301C, 6'd0);
    expect_c("eret3", 1, 1'b0, 0, 32'h0, 0, 32'h0); tick();
    drv(5'd12, 32'hFFFF_FC01, 1'b1, 1'b0, 5'd0, 1'b0, 32'h3020, 6'd0);
    expect_c("sr_all", 1, 1'b0, 1, 32'h0000_0400, 0, 32'h0); tick();
    drv(5'd12, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h3024, 6'd0);
    expect_c("sr_mask", 0, 1'b0, 1, 32'h0000_FC01, 0, 32'h0); tick();

    // Interrupt beats exception; a simultaneous mtc0 EPC is dropped.
    drv(5'd14, 32'h0000_1234, 1'b1, 1'b0, 5'd4, 1'b0, 32'h3050, 6'b000100);
    expect_c("int_vs_exc", 1, 1'b1, 1, 32'h0000_300C, 0, 32'h0); tick();
    drv(5'd13, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h3054, 6'd0);
    expect_c("ive_cause", 1, 1'b0, 1, 32'h0000_1000, 1, 32'h3050); tick();
    drv(5'd13, 32'd0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h3058, 6'd0);
    expect_c("eret4", 1, 1'b0, 1, 32'h0, 0, 32'h0); tick();

    // mtc0 EPC is word-aligned and becomes visible only after the edge.
    drv(5'd14, 32'h1234_5677, 1'b1, 1'b0, 5'd0, 1'b0, 32'h305C, 6'd0);
    expect_c("mtc0_epc", 1, 1'b0, 1, 32'h0000_3050, 0, 32'h0); tick();
    drv(5'd14, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h3060, 6'd0);
    expect_c("epc_new", 0, 1'b0, 1, 32'h1234_5674, 1, 32'h1234_5674); tick();
    drv(5'd13, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0, 1'b0, 32'h3064, 6'd0);
    expect_c("wr_cause", 0, 1'b0, 1, 32'h0, 0, 32'h0); tick();
    drv(5'd15, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h3068, 6'd0);
    expect_c("ro_cause", 0, 1'b0, 1, PRID, 0, 32'h0); tick();
    drv(5'd13, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h306C, 6'd0);
    expect_c("ro_cause2", 0, 1'b0, 1, 32'h0, 0, 32'h0); tick();
    drv(5'd7, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h3070, 6'd0);
    expect_c("rd_other", 0, 1'b0, 1, 32'h0, 1, 32'h1234_5674); tick();

    // Delay-slot exception at PC 0: EPC wraps.
    drv(5'd13, 32'd0, 1'b0, 1'b0, 5'd10, 1'b1, 32'h0, 6'd0);
    expect_c("wrap_take", 1, 1'b1, 0, 32'h0, 0, 32'h0); tick();
    drv(5'd13, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h4, 6'd0);
    expect_c("wrap_cause", 1, 1'b0, 1, 32'h8000_0028, 1, 32'hFFFF_FFFC); tick();

    // Asynchronous reset mid-handler, checked before the next clock edge.
    reset = 1'b0;
    drv(5'd12, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h8, 6'b111111);
    expect_c("rst_async", 1, 1'b0, 1, 32'h0, 1, EPC_RESET); tick();
    reset = 1'b1;
    drv(5'd13, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'hC, 6'd0);
    expect_c("rst_cause", 1, 1'b0, 1, 32'h0, 1, EPC_RESET); tick();

    repeat (4) tick();
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
